// File: rtl/mic3_capture_scheduler.sv
// PmodMIC3 frame sequencer: drives cs/sck and captures one 16-bit ADC frame, either
// periodically or on request, handing the 12-bit sample out through a valid/ready register.
module mic3_capture_scheduler #(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned SAMPLE_PERIOD = 2500,
  parameter int unsigned QUIET_CYCLES  = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        periodic,
  input  logic        start,
  output logic        cs,
  output logic        sck,
  input  logic        sdo,
  output logic [11:0] sample,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        overrun,
  input  logic        overrun_clear,
  output logic        busy
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned PER_W  = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned QUI_W  = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;
  localparam int unsigned HALF_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2,
    ST_QUIET = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [HALF_W-1:0]   half_q, half_d;
  logic [QUI_W-1:0]    quiet_q, quiet_d;
  logic [PER_W-1:0]    per_q, per_d;
  logic [11:0]         shift_q, shift_d;
  logic [11:0]         sample_q, sample_d;
  logic                sample_valid_q, sample_valid_d;
  logic                overrun_q, overrun_d;
  logic                cs_q, cs_d;
  logic                sck_q, sck_d;
  logic                busy_q, busy_d;

  logic tick;
  logic launch;
  logic load;
  logic xfer;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d        = state_q;
    div_d          = div_q;
    half_d         = half_q;
    quiet_d        = quiet_q;
    per_d          = '0;
    shift_d        = shift_q;
    load           = 1'b0;

    tick   = enable && periodic && (per_q == '0);
    launch = enable && (periodic ? tick : start);

    if (enable && periodic) begin
      per_d = (per_q == PER_W'(SAMPLE_PERIOD - 1)) ? '0 : per_q + PER_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_d = ST_SHIFT;
          div_d   = '0;
          half_d  = '0;
        end
      end
      ST_SHIFT: begin
        // Last low cycle of each sck period, just before the rising edge
        if (div_q == DIV_W'(CLK_DIV - 1) && half_q[0]) begin
          shift_d = {shift_q[10:0], sdo};
        end
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d = '0;
          if (half_q == HALF_W'(31)) begin
            state_d = ST_DONE;
          end else begin
            half_d = half_q + HALF_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_DONE: begin
        load    = 1'b1;
        state_d = ST_QUIET;
        quiet_d = '0;
      end
      ST_QUIET: begin
        if (quiet_q == QUI_W'(QUIET_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          quiet_d = quiet_q + QUI_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    xfer           = sample_valid_q && sample_ready;
    sample_d       = load ? shift_q : sample_q;
    sample_valid_d = load || (sample_valid_q && !sample_ready);
    // A simultaneous overrun event beats the clear request
    overrun_d      = (load && sample_valid_q && !xfer) || (overrun_q && !overrun_clear);

    cs_d   = (state_d != ST_SHIFT);
    sck_d  = (state_d == ST_SHIFT) ? ~half_d[0] : 1'b1;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      div_q          <= '0;
      half_q         <= '0;
      quiet_q        <= '0;
      per_q          <= '0;
      shift_q        <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
      cs_q           <= 1'b1;
      sck_q          <= 1'b1;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      div_q          <= div_d;
      half_q         <= half_d;
      quiet_q        <= quiet_d;
      per_q          <= per_d;
      shift_q        <= shift_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
      cs_q           <= cs_d;
      sck_q          <= sck_d;
      busy_q         <= busy_d;
    end
  end

  assign cs           = cs_q;
  assign sck          = sck_q;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign overrun      = overrun_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_mic3_capture_scheduler.sv
// Directed bench for mic3_capture_scheduler with a simple PmodMIC3 ADC model.
module tb_mic3_capture_scheduler;

  localparam int unsigned CLK_DIV       = 4;
  localparam int unsigned SAMPLE_PERIOD = 200;
  localparam int unsigned QUIET_CYCLES  = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        periodic;
  logic        start;
  logic        cs;
  logic        sck;
  logic        sdo;
  logic [11:0] sample;
  logic        sample_valid;
  logic        sample_ready;
  logic        overrun;
  logic        overrun_clear;
  logic        busy;

  int          n_tests = 0;
  int          n_fail  = 0;

  logic [15:0] adc_word = 16'h0000;
  int          adc_falls = 0;

  mic3_capture_scheduler #(
    .CLK_DIV      (CLK_DIV),
    .SAMPLE_PERIOD(SAMPLE_PERIOD),
    .QUIET_CYCLES (QUIET_CYCLES)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .periodic     (periodic),
    .start        (start),
    .cs           (cs),
    .sck          (sck),
    .sdo          (sdo),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .overrun_clear(overrun_clear),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  // ADC model: a new bit, MSB first, after every sck falling edge of the frame
  always @(negedge cs or negedge sck) begin
    if (sck) begin
      adc_falls = 0;
    end else if (!cs && adc_falls < 16) begin
      sdo <= adc_word[4'(15 - adc_falls)];
      adc_falls = adc_falls + 1;
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Launches one frame with start and observes 300 cycles
  task automatic run_frame(input logic [15:0] word, input int restart_at, input int drop_at,
                           input int ready_at, output int cs_low, output int sck_falls,
                           output int cs_falls, output int valid_at);
    logic prev_cs, prev_sck, prev_v;
    adc_word  = word;
    cs_low    = 0;
    sck_falls = 0;
    cs_falls  = 0;
    valid_at  = -1;
    prev_cs   = cs;
    prev_sck  = sck;
    prev_v    = sample_valid;
    start     = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      step();
      if (!cs) cs_low++;
      if (prev_cs && !cs) cs_falls++;
      if (prev_sck && !sck) sck_falls++;
      if (!prev_v && sample_valid && valid_at < 0) valid_at = n;
      prev_cs  = cs;
      prev_sck = sck;
      prev_v   = sample_valid;
      start        = (n == restart_at);
      sample_ready = (n == ready_at);
      if (n == drop_at) enable = 1'b0;
    end
    start        = 1'b0;
    sample_ready = 1'b0;
  endtask

  task automatic consume();
    sample_ready = 1'b1;
    step();
    sample_ready = 1'b0;
  endtask

  int cs_low, sck_falls, cs_falls, valid_at;
  int fall_cnt, last_fall, bad_gaps;
  logic prev_cs_p;

  initial begin
    reset_n       = 1'b0;
    enable        = 1'b0;
    periodic      = 1'b0;
    start         = 1'b0;
    sample_ready  = 1'b0;
    overrun_clear = 1'b0;
    sdo           = 1'b0;

    #23;
    check_eq("rst_cs", 32'(cs), 1);
    check_eq("rst_sck", 32'(sck), 1);
    check_eq("rst_sample", 32'(sample), 0);
    check_eq("rst_valid", 32'(sample_valid), 0);
    check_eq("rst_overrun", 32'(overrun), 0);
    check_eq("rst_busy", 32'(busy), 0);
    reset_n = 1'b1;
    step();
    enable = 1'b1;
    step();

    // Single shot
    run_frame(16'h0A5C, 0, 0, 0, cs_low, sck_falls, cs_falls, valid_at);
    check_eq("ss_cs_low", cs_low, 128);
    check_eq("ss_sck_falls", sck_falls, 16);
    check_eq("ss_cs_falls", cs_falls, 1);
    check_eq("ss_valid_at", valid_at, 130);
    check_eq("ss_sample", 32'(sample), 32'h0A5C);
    check_eq("ss_busy_end", 32'(busy), 0);
    consume();
    check_eq("ss_consumed", 32'(sample_valid), 0);

    // Periodic
    periodic     = 1'b1;
    sample_ready = 1'b1;
    fall_cnt     = 0;
    last_fall    = -1;
    bad_gaps     = 0;
    prev_cs_p    = cs;
    for (int n = 1; n <= 1000; n++) begin
      step();
      if (prev_cs_p && !cs) begin
        if (last_fall >= 0 && (n - last_fall) != 200) bad_gaps++;
        last_fall = n;
        fall_cnt++;
      end
      prev_cs_p = cs;
    end
    periodic = 1'b0;
    check_eq("per_frames", fall_cnt, 5);
    check_eq("per_bad_gaps", bad_gaps, 0);
    check_eq("per_overrun", 32'(overrun), 0);
    check_eq("per_sample", 32'(sample), 32'h0A5C);
    repeat (200) step();
    sample_ready = 1'b0;
    check_eq("per_idle", 32'(busy), 0);
    check_eq("per_drained", 32'(sample_valid), 0);

    // Overrun
    run_frame(16'h0123, 0, 0, 0, cs_low, sck_falls, cs_falls, valid_at);
    check_eq("ov_first_sample", 32'(sample), 32'h123);
    check_eq("ov_no_overrun_yet", 32'(overrun), 0);
    run_frame(16'h0BEE, 0, 0, 0, cs_low, sck_falls, cs_falls, valid_at);
    check_eq("ov_sample", 32'(sample), 32'hBEE);
    check_eq("ov_flag", 32'(overrun), 1);
    check_eq("ov_valid", 32'(sample_valid), 1);
    overrun_clear = 1'b1;
    step();
    overrun_clear = 1'b0;
    check_eq("ov_cleared", 32'(overrun), 0);
    check_eq("ov_valid_kept", 32'(sample_valid), 1);
    consume();
    check_eq("ov_consumed", 32'(sample_valid), 0);

    // Transfer in the DONE cycle
    run_frame(16'h0111, 0, 0, 0, cs_low, sck_falls, cs_falls, valid_at);
    run_frame(16'h0222, 0, 0, 129, cs_low, sck_falls, cs_falls, valid_at);
    check_eq("sim_valid", 32'(sample_valid), 1);
    check_eq("sim_sample", 32'(sample), 32'h222);
    check_eq("sim_overrun", 32'(overrun), 0);
    consume();
    check_eq("sim_consumed", 32'(sample_valid), 0);

    // Start repeated during SHIFT
    run_frame(16'h0333, 10, 0, 0, cs_low, sck_falls, cs_falls, valid_at);
    check_eq("bsy_cs_falls", cs_falls, 1);
    check_eq("bsy_cs_low", cs_low, 128);
    check_eq("bsy_sample", 32'(sample), 32'h333);
    consume();

    // Enable dropped mid-SHIFT
    run_frame(16'h0444, 10, 40, 0, cs_low, sck_falls, cs_falls, valid_at);
    check_eq("en_cs_falls", cs_falls, 1);
    check_eq("en_valid_at", valid_at, 130);
    check_eq("en_sample", 32'(sample), 32'h444);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check_eq("en_no_launch", 32'(cs), 1);
    check_eq("en_no_busy", 32'(busy), 0);
    enable = 1'b1;

    // Reset at c=50, with the previous sample still unconsumed
    adc_word = 16'h0555;
    start    = 1'b1;
    step();
    start    = 1'b0;
    repeat (50) step();
    check_eq("rm_mid_frame", 32'(cs), 0);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rm_cs", 32'(cs), 1);
    check_eq("rm_sck", 32'(sck), 1);
    check_eq("rm_valid", 32'(sample_valid), 0);
    check_eq("rm_busy", 32'(busy), 0);
    step();
    reset_n = 1'b1;
    step();
    run_frame(16'h0777, 0, 0, 0, cs_low, sck_falls, cs_falls, valid_at);
    check_eq("rm_cs_low", cs_low, 128);
    check_eq("rm_sck_falls", sck_falls, 16);
    check_eq("rm_valid_at", valid_at, 130);
    check_eq("rm_sample", 32'(sample), 32'h777);
    check_eq("rm_overrun", 32'(overrun), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mic3_capture_scheduler.md
# mic3_capture_scheduler

Frame sequencer for the Digilent PmodMIC3 (ADCS7476-style 16-bit SPI frame: 4 leading zeros, then 12 data bits MSB first). It generates `cs`/`sck`, captures one frame either periodically at a programmable sample rate or on a single-shot request, and extracts the 12-bit sample. The sample is presented to downstream audio logic (note recognition, level meters) through a valid/ready register with a sticky overrun flag. It sits between the PMOD pins and the sample consumers.

## Interface
- `CLK_DIV`, default 4: clock cycles per `sck` half-period; must be ≥1.
- `SAMPLE_PERIOD`, default 2500: clock cycles between periodic frame starts (20 kHz at 50 MHz); must be ≥ 32*CLK_DIV + QUIET_CYCLES + 2.
- `QUIET_CYCLES`, default 4: minimum `cs`-high cycles after each frame; must be ≥1.
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  master enable; when low, no new frames start.
- `periodic`  in  1  1 = frames launched by the period timer; 0 = frames launched by `start`.
- `start`  in  1  single-shot request pulse (honoured only when `periodic`=0).
- `cs`  out  1  chip select, active low.
- `sck`  out  1  SPI clock, idles high.
- `sdo`  in  1  serial data from the microphone ADC.
- `sample`  out  12  last captured sample.
- `sample_valid`  out  1  `sample` holds an unconsumed sample.
- `sample_ready`  in  1  consumer accepts `sample` when high with `sample_valid`.
- `overrun`  out  1  sticky: an unconsumed sample was overwritten.
- `overrun_clear`  in  1  clears `overrun`.
- `busy`  out  1  high in SHIFT, DONE and QUIET.

## Operation
- Reset values: `cs`=1, `sck`=1, `sample`=0, `sample_valid`=0, `overrun`=0, `busy`=0; state IDLE; period counter 0. Reset asserted mid-frame aborts immediately: `cs` and `sck` return high asynchronously and no partial sample is delivered.
- States: IDLE → SHIFT → DONE → QUIET → IDLE.
- IDLE: launch condition = `enable` && (`periodic` ? period tick : `start`). On launch go SHIFT. A start and a tick in the same cycle give one frame.
- Period timer: counts 0..SAMPLE_PERIOD-1 while `enable` && `periodic`, and wraps. The tick is count==0. It is held at 0 otherwise, so the first tick comes one cycle after `periodic` and `enable` are both high. Ticks outside IDLE are dropped, with no queueing.
- SHIFT: frame counter c runs 0..32*CLK_DIV-1. `sck` = 1 when floor(c/CLK_DIV) is even, else 0, giving 16 falling edges. `sdo` shifts into a 16-bit register, MSB first, on cycles c = CLK_DIV*(2k+2)-1, k=0..15 (the last low cycle before each rising edge). After c = 32*CLK_DIV-1, go DONE.
- DONE (1 cycle): `cs`=1. Load `sample` ← shift[11:0]; the leading 4 bits are discarded and not checked. Set `sample_valid`. Go QUIET.
- QUIET: `cs`=1 for QUIET_CYCLES cycles, then go IDLE.
- `start` outside IDLE is ignored. `enable` falling mid-frame lets the frame complete, including delivery.
- Output handshake: a transfer occurs when `sample_valid` && `sample_ready`; it clears `sample_valid` next cycle unless a new sample loads.
  - DONE with `sample_valid`=1 and no transfer that cycle: overwrite `sample`, set `overrun`.
  - DONE coinciding with a transfer: old sample consumed, new sample loaded, `sample_valid` stays 1, no overrun.
  - `overrun_clear` has priority over setting `overrun` only when no overrun event occurs the same cycle. A simultaneous set wins.

## Timing
- Launch sampled at edge t: `cs` low and `busy` high from t+1. `sck` first falls at t+1+CLK_DIV.
- `cs` is low for exactly 32*CLK_DIV cycles. `sample_valid` rises at t+32*CLK_DIV+2. IDLE is re-entered at t+32*CLK_DIV+2+QUIET_CYCLES.
- All outputs are registered with no combinational path from inputs to outputs. `sdo` is used directly; it is synchronous to the self-generated `sck`.

## Test plan
- Single shot, CLK_DIV=4: pulse `start` with `periodic`=0, ADC model driving 0000_1010_0101_1100. Required: `cs` low 128 cycles, 16 `sck` falls, `sample`=0xA5C, `sample_valid` 130 cycles after start.
- Periodic, SAMPLE_PERIOD=200: `enable`=`periodic`=1 for 1000 cycles, `sample_ready`=1. Required: 5 frames, `cs` falling edges exactly 200 cycles apart, `overrun`=0.
- Overrun: 2 frames with `sample_ready`=0. Required: `sample` = second value, `overrun`=1. Then `overrun_clear` → 0. Then `sample_ready` → `sample_valid` drops next cycle.
- Simultaneous event: `sample_ready` asserted exactly in the DONE cycle of frame 2. Required: `sample_valid` stays 1, `sample` = frame 2 value, `overrun`=0.
- Busy rules: `start` repeated during SHIFT is ignored (one frame only). `enable` dropped mid-SHIFT: frame still delivered, no further frames.
- Reset mid-frame: `reset_n` low at c=50. Required: `cs`=`sck`=1 and `sample_valid`=0 immediately. After release, the next `start` gives a clean frame.
